tremor_rx_frame_parser: RTL and testbench

Receive-side counterpart of the tremor frame transmitter. Consumes the byte stream delivered by a UART receiver, hunts for the header byte, collects a fixed number of payload bytes, and presents the reassembled word (frame/position data) with a one-cycle valid strobe. It sits between the UART RX core and whatever consumer needs the detected tremor data, such as a loopback checker or a host-side capture FPGA.

---
 rtl/tremor_if_pkg.sv | 13 +
 rtl/rx_timeout_counter.sv | 30 +++
 rtl/tremor_rx_frame_parser.sv | 118 +++++++++++
 tb/tb_tremor_rx_frame_parser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tremor_if_pkg.sv
// Shared tremor link definitions: receiver state encoding, the default header byte
// and the UART symbol width.
package tremor_if_pkg;

   localparam int         TREMOR_UART_BIT_WIDTH = 8;
   localparam logic [7:0] TREMOR_HEADER         = 8'hA5;

   typedef enum logic {
      RX_IDLE    = 1'b0,
      RX_PAYLOAD = 1'b1
   } rx_state_t;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter for the tremor receiver. expired is combinational so
// the parser can abort on the very clock the idle budget runs out.
module rx_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   // A clear in the same cycle (a byte arriving) always beats expiry.
   assign expired = run && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tremor_rx_frame_parser.sv
// Tremor receive frame parser: hunts for HEADER, gathers PAYLOAD_BYTES bytes LSB-first
// and publishes the word with a one-cycle oValid. Define RX_FRAME_TIMEOUT_EN for the inter-byte timeout.
module tremor_rx_frame_parser
   import tremor_if_pkg::*;
#(
   parameter int                         UART_BIT_WIDTH = TREMOR_UART_BIT_WIDTH,
   parameter logic [UART_BIT_WIDTH-1:0]  HEADER         = TREMOR_HEADER,
   parameter int                         PAYLOAD_BYTES  = 4,
   parameter int                         DATA_BIT_WIDTH = PAYLOAD_BYTES * UART_BIT_WIDTH,
   parameter int                         TIMEOUT_CYCLES = 100000
) (
   input  logic                      clk,
   input  logic                      n_rst,
   // Byte input is valid-only: a byte is consumed on every clock RxValid is high,
   // there is no ready/backpressure, and RxError flags the byte of that same cycle.
   input  logic                      RxValid,
   input  logic [UART_BIT_WIDTH-1:0] RxData,
   input  logic                      RxError,
   output logic [DATA_BIT_WIDTH-1:0] oData,
   output logic                      oValid,
   output logic                      FrameErr,
   output logic [15:0]               FrameCount,
   output rx_state_t                 DbgState
);

   localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

   if (PAYLOAD_BYTES < 1) begin : gBadPayload
      $error("PAYLOAD_BYTES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   rx_state_t                 state, stateNext;
   logic [IDX_W-1:0]          idx, idxNext;
   logic [DATA_BIT_WIDTH-1:0] shadow, shadowNext;
   logic                      frameDone, frameAbort;
   logic                      timeoutHit;

`ifdef RX_FRAME_TIMEOUT_EN
   rx_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) uTimeout (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (RxValid || (state == RX_IDLE)),
      .run     ((state == RX_PAYLOAD) && !RxValid),
      .expired (timeoutHit)
   );
`else
   assign timeoutHit = 1'b0;
`endif

   assign DbgState = state;

   always_comb begin
      stateNext  = state;
      idxNext    = idx;
      shadowNext = shadow;
      frameDone  = 1'b0;
      frameAbort = 1'b0;
      case (state)
         RX_IDLE: begin
            if (RxValid && !RxError && (RxData == HEADER)) begin
               stateNext = RX_PAYLOAD;
               idxNext   = '0;
            end
         end
         RX_PAYLOAD: begin
            if (RxError || (!RxValid && timeoutHit)) begin
               frameAbort = 1'b1;
               stateNext  = RX_IDLE;
               idxNext    = '0;
               shadowNext = '0;
            end else if (RxValid) begin
               // Header value mid-frame is plain data; no resync.
               shadowNext[idx*UART_BIT_WIDTH +: UART_BIT_WIDTH] = RxData;
               if (idx == LAST_IDX) begin
                  frameDone = 1'b1;
                  stateNext = RX_IDLE;
                  idxNext   = '0;
               end else begin
                  idxNext = idx + 1'b1;
               end
            end
         end
         default: begin
            stateNext = RX_IDLE;
            idxNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= RX_IDLE;
         idx        <= '0;
         shadow     <= '0;
         oData      <= '0;
         oValid     <= 1'b0;
         FrameErr   <= 1'b0;
         FrameCount <= '0;
      end else begin
         state    <= stateNext;
         idx      <= idxNext;
         shadow   <= shadowNext;
         oValid   <= frameDone;
         FrameErr <= frameAbort;
         if (frameDone) begin
            oData      <= shadowNext;
            FrameCount <= FrameCount + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tremor_rx_frame_parser.sv
// Directed bench for tremor_rx_frame_parser with PAYLOAD_BYTES=3, HEADER=A5, TIMEOUT_CYCLES=20.
// Honours RX_FRAME_TIMEOUT_EN so the same bench covers both builds.
module tb_tremor_rx_frame_parser;
   import tremor_if_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        RxValid = 1'b0;
   logic [7:0]  RxData = 8'h00;
   logic        RxError = 1'b0;
   logic [23:0] oData;
   logic        oValid;
   logic        FrameErr;
   logic [15:0] FrameCount;
   rx_state_t   DbgState;

   int passCnt = 0;
   int totalCnt = 0;

   // monitor bookkeeping (written only by the always blocks below)
   int cycle = 0;
   int validCnt = 0;
   int errCnt = 0;
   int overlapCnt = 0;
   int lastValidCycle = 0;
   int prevValidCycle = 0;

   tremor_rx_frame_parser #(
      .UART_BIT_WIDTH (8),
      .HEADER         (8'hA5),
      .PAYLOAD_BYTES  (3),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .RxValid    (RxValid),
      .RxData     (RxData),
      .RxError    (RxError),
      .oData      (oData),
      .oValid     (oValid),
      .FrameErr   (FrameErr),
      .FrameCount (FrameCount),
      .DbgState   (DbgState)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (n_rst) begin
         if (oValid) begin
            validCnt       <= validCnt + 1;
            prevValidCycle <= lastValidCycle;
            lastValidCycle <= cycle;
         end
         if (FrameErr) errCnt <= errCnt + 1;
         if (oValid && FrameErr) overlapCnt <= overlapCnt + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      n_rst = 1'b0; RxValid = 1'b0; RxError = 1'b0; RxData = 8'h00;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic err = 1'b0);
      @(negedge clk);
      RxValid = 1'b1; RxData = b; RxError = err;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         RxValid = 1'b0; RxError = 1'b0; RxData = 8'h00;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      @(negedge clk); #1;
      totalCnt++;
      if (oData !== 24'h0 || oValid !== 1'b0 || FrameErr !== 1'b0 || FrameCount !== 16'h0)
         $display("FAIL reset_outputs got data=%h v=%b e=%b cnt=%0d want 0/0/0/0", oData, oValid, FrameErr, FrameCount);
      else passCnt++;
      totalCnt++;
      if (DbgState !== RX_IDLE) $display("FAIL reset_state got %0d want %0d", DbgState, RX_IDLE);
      else passCnt++;
   endtask

   task automatic test_basic_frame();
      int v0;
      apply_reset();
      v0 = validCnt;
      drive_byte(8'hA5); drive_byte(8'h11); drive_byte(8'h22); #1;
      totalCnt++;
      if (oData !== 24'h0 || oValid !== 1'b0)
         $display("FAIL basic_no_partial got data=%h v=%b want 000000/0", oData, oValid);
      else passCnt++;
      drive_byte(8'h33);
      idle(1); #1;
      totalCnt++;
      if (oValid !== 1'b1 || oData !== 24'h332211 || FrameCount !== 16'd1)
         $display("FAIL basic_frame got v=%b data=%h cnt=%0d want 1/332211/1", oValid, oData, FrameCount);
      else passCnt++;
      idle(2); #1;
      totalCnt++;
      if (oValid !== 1'b0 || (validCnt - v0) != 1)
         $display("FAIL basic_single_pulse got v=%b pulses=%0d want 0/1", oValid, validCnt - v0);
      else passCnt++;
   endtask

   task automatic test_hunt();
      apply_reset();
      drive_byte(8'h00); drive_byte(8'h7F); drive_byte(8'hA5);
      drive_byte(8'hA5); drive_byte(8'h01); drive_byte(8'h02);
      idle(2); #1;
      totalCnt++;
      if (oData !== 24'h0201A5 || FrameCount !== 16'd1)
         $display("FAIL hunt_frame got data=%h cnt=%0d want 0201A5/1", oData, FrameCount);
      else passCnt++;
   endtask

   task automatic test_rx_error();
      int e0;
      apply_reset();
      drive_byte(8'hA5); drive_byte(8'h77); drive_byte(8'h88); drive_byte(8'h99);
      e0 = errCnt;
      drive_byte(8'hA5); drive_byte(8'h11); drive_byte(8'h22, 1'b1);
      idle(1); #1;
      totalCnt++;
      if (FrameErr !== 1'b1 || oValid !== 1'b0 || oData !== 24'h998877)
         $display("FAIL err_pulse got e=%b v=%b data=%h want 1/0/998877", FrameErr, oValid, oData);
      else passCnt++;
      idle(1); #1;
      totalCnt++;
      if (FrameErr !== 1'b0 || DbgState !== RX_IDLE)
         $display("FAIL err_one_cycle got e=%b state=%0d want 0/%0d", FrameErr, DbgState, RX_IDLE);
      else passCnt++;
      // a header flagged with RxError in IDLE must not open a frame
      drive_byte(8'hA5, 1'b1);
      drive_byte(8'hA5); drive_byte(8'h44); drive_byte(8'h55); drive_byte(8'h66);
      idle(2); #1;
      totalCnt++;
      if (oData !== 24'h665544 || FrameCount !== 16'd2 || (errCnt - e0) != 1)
         $display("FAIL err_recover got data=%h cnt=%0d errs=%0d want 665544/2/1", oData, FrameCount, errCnt - e0);
      else passCnt++;
   endtask

   task automatic test_timeout();
      int v0;
      int e0;
      apply_reset();
      v0 = validCnt; e0 = errCnt;
      drive_byte(8'hA5); drive_byte(8'h11);
      idle(20); #2;
      totalCnt++;
      if (FrameErr !== 1'b0) $display("FAIL timeout_early got e=%b want 0", FrameErr);
      else passCnt++;
      idle(1); #2;
`ifdef RX_FRAME_TIMEOUT_EN
      totalCnt++;
      if (FrameErr !== 1'b1) $display("FAIL timeout_fire got e=%b want 1", FrameErr);
      else passCnt++;
`else
      totalCnt++;
      if (FrameErr !== 1'b0 || DbgState !== RX_PAYLOAD)
         $display("FAIL timeout_absent got e=%b state=%0d want 0/%0d", FrameErr, DbgState, RX_PAYLOAD);
      else passCnt++;
`endif
      idle(4);
      drive_byte(8'h22); drive_byte(8'h33);
      idle(2); #1;
`ifdef RX_FRAME_TIMEOUT_EN
      totalCnt++;
      if (oData !== 24'h0 || FrameCount !== 16'd0 || (validCnt - v0) != 0 || (errCnt - e0) != 1)
         $display("FAIL timeout_discard got data=%h cnt=%0d pulses=%0d errs=%0d want 000000/0/0/1",
                  oData, FrameCount, validCnt - v0, errCnt - e0);
      else passCnt++;
`else
      totalCnt++;
      if (oData !== 24'h332211 || FrameCount !== 16'd1 || (errCnt - e0) != 0)
         $display("FAIL timeout_wait got data=%h cnt=%0d errs=%0d want 332211/1/0", oData, FrameCount, errCnt - e0);
      else passCnt++;
`endif
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      apply_reset();
      drive_byte(8'hA5); drive_byte(8'hAA); drive_byte(8'hBB); drive_byte(8'hCC);
      drive_byte(8'hA5); drive_byte(8'h11);
      idle(1); #1;
      totalCnt++;
      if (oData !== 24'hCCBBAA || FrameCount !== 16'd1)
         $display("FAIL rst_pre got data=%h cnt=%0d want CCBBAA/1", oData, FrameCount);
      else passCnt++;
      e0 = errCnt;
      n_rst = 1'b0; #1;
      totalCnt++;
      if (oData !== 24'h0 || FrameCount !== 16'h0 || oValid !== 1'b0 || FrameErr !== 1'b0 || DbgState !== RX_IDLE)
         $display("FAIL rst_async got data=%h cnt=%0d v=%b e=%b state=%0d want all 0",
                  oData, FrameCount, oValid, FrameErr, DbgState);
      else passCnt++;
      @(negedge clk); n_rst = 1'b1;
      drive_byte(8'h22);
      drive_byte(8'hA5); drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
      idle(2); #1;
      totalCnt++;
      if (oData !== 24'h030201 || FrameCount !== 16'd1 || (errCnt - e0) != 0)
         $display("FAIL rst_recover got data=%h cnt=%0d errs=%0d want 030201/1/0", oData, FrameCount, errCnt - e0);
      else passCnt++;
   endtask

   task automatic test_back_to_back();
      int v0;
      apply_reset();
      v0 = validCnt;
      drive_byte(8'hA5); drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
      drive_byte(8'hA5); drive_byte(8'h44); drive_byte(8'h55); drive_byte(8'h66);
      idle(3); #1;
      totalCnt++;
      if ((validCnt - v0) != 2 || (lastValidCycle - prevValidCycle) != 4)
         $display("FAIL b2b_pulses got pulses=%0d gap=%0d want 2/4", validCnt - v0, lastValidCycle - prevValidCycle);
      else passCnt++;
      totalCnt++;
      if (oData !== 24'h665544 || FrameCount !== 16'd2)
         $display("FAIL b2b_frame got data=%h cnt=%0d want 665544/2", oData, FrameCount);
      else passCnt++;
      totalCnt++;
      if (overlapCnt != 0) $display("FAIL valid_err_overlap got %0d want 0", overlapCnt);
      else passCnt++;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_hunt();
      test_rx_error();
      test_timeout();
      test_reset_mid_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
